// File: rtl/condlogic_pipe_v.sv
// Execute-stage condition unit: NZCV register in FLAG_GROUPS write slices, condition evaluation,
// side-effect gating, and the registered Memory-stage copy. COND_STATS_EN adds executed/annulled counters.
module condlogic_pipe_v #(
  parameter int FLAG_GROUPS = 2
`ifdef COND_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   StallE,
  input  logic                   FlushE,
  input  logic                   ValidE,
  input  logic [3:0]             Cond,
  input  logic [3:0]             ALUFlags,
  input  logic [FLAG_GROUPS-1:0] FlagW,
  input  logic                   PCS,
  input  logic                   RegW,
  input  logic                   MemW,
  output logic [3:0]             Flags,
  output logic                   CondExE,
  output logic                   PCSrcE,
  output logic                   RegWriteM,
  output logic                   MemWriteM,
  output logic                   PCSrcM
`ifdef COND_STATS_EN
  , output logic [CNT_W-1:0]     CntExec,
  output logic [CNT_W-1:0]       CntAnnul
`endif
);

  logic       n, z, c, v;
  logic       cond_pass;
  logic       live;
  logic [3:0] wmask;

  assign {n, z, c, v} = Flags;

  always_comb begin
    cond_pass = 1'b0;
    case (Cond)
      4'h0: cond_pass = z;
      4'h1: cond_pass = !z;
      4'h2: cond_pass = c;
      4'h3: cond_pass = !c;
      4'h4: cond_pass = n;
      4'h5: cond_pass = !n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = !v;
      4'h8: cond_pass = c & !z;
      4'h9: cond_pass = !c | z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = !z & (n == v);
      4'hD: cond_pass = z | (n != v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign live    = ValidE & !FlushE;
  assign CondExE = live & cond_pass;
  assign PCSrcE  = PCS & CondExE;

  // Flag bit b belongs to slice b*FLAG_GROUPS/4, so each bit picks up its slice's enable.
  for (genvar b = 0; b < 4; b++) begin : g_wmask
    assign wmask[b] = FlagW[(b * FLAG_GROUPS) / 4];
  end

  always_ff @(posedge clk) begin
    if (reset)
      Flags <= 4'b0000;
    else if (!StallE && CondExE)
      Flags <= (Flags & ~wmask) | (ALUFlags & wmask);
  end

  // Stall beats flush: a held stage must not lose the instruction already in M.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      PCSrcM    <= 1'b0;
    end else if (FlushE && !StallE) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      PCSrcM    <= 1'b0;
    end else if (!StallE) begin
      RegWriteM <= RegW & CondExE;
      MemWriteM <= MemW & CondExE;
      PCSrcM    <= PCS & CondExE;
    end
  end

`ifdef COND_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      CntExec  <= '0;
      CntAnnul <= '0;
    end else if (!StallE && live) begin
      if (cond_pass) CntExec  <= CntExec + 1'b1;
      else           CntAnnul <= CntAnnul + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_condlogic_pipe_v.sv
// Scoreboard bench for condlogic_pipe_v: directed test-plan sequences then random traffic,
// checked against an architectural model of NZCV and the M stage.
module tb_condlogic_pipe_v;
  localparam int FG = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, StallE, FlushE, ValidE, PCS, RegW, MemW;
  logic [3:0]    Cond, ALUFlags;
  logic [FG-1:0] FlagW;
  logic [3:0]    Flags;
  logic          CondExE, PCSrcE, RegWriteM, MemWriteM, PCSrcM;
  logic [CW-1:0] CntExec, CntAnnul;

  always #5 clk = ~clk;

`ifdef COND_STATS_EN
  condlogic_pipe_v #(.FLAG_GROUPS(FG), .CNT_W(CW)) dut (
`else
  condlogic_pipe_v #(.FLAG_GROUPS(FG)) dut (
`endif
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidE(ValidE),
    .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .Flags(Flags), .CondExE(CondExE), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .PCSrcM(PCSrcM)
`ifdef COND_STATS_EN
    , .CntExec(CntExec), .CntAnnul(CntAnnul)
`endif
  );
`ifndef COND_STATS_EN
  assign CntExec  = '0;
  assign CntAnnul = '0;
`endif

  typedef struct {
    logic          cex, pcse, regm, memm, pcsm;
    logic [3:0]    flags;
    logic [CW-1:0] cexec, cannul;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Architectural state of the model
  logic [3:0]    mflags;
  logic          mreg, mmem, mpcs;
  logic [CW-1:0] mexec, mannul;

  // Odd codes below E are the inverse of the even code before them.
  function automatic logic model_pass(input logic [3:0] cd, input logic [3:0] f);
    logic fn, fz, fc, fv, base;
    {fn, fz, fc, fv} = f;
    if (cd == 4'hE) return 1'b1;
    if (cd == 4'hF) return 1'b0;
    case (cd >> 1)
      0: base = fz;
      1: base = fc;
      2: base = fn;
      3: base = fv;
      4: base = fc && !fz;
      5: base = (fn == fv);
      6: base = !fz && (fn == fv);
      default: base = 1'b0;
    endcase
    return base ^ cd[0];
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t r;
      r = q.pop_front();
      chk("CondExE",   {15'd0, CondExE},   {15'd0, r.cex});
      chk("PCSrcE",    {15'd0, PCSrcE},    {15'd0, r.pcse});
      chk("Flags",     {12'd0, Flags},     {12'd0, r.flags});
      chk("RegWriteM", {15'd0, RegWriteM}, {15'd0, r.regm});
      chk("MemWriteM", {15'd0, MemWriteM}, {15'd0, r.memm});
      chk("PCSrcM",    {15'd0, PCSrcM},    {15'd0, r.pcsm});
`ifdef COND_STATS_EN
      chk("CntExec",   {12'd0, CntExec},   {12'd0, r.cexec});
      chk("CntAnnul",  {12'd0, CntAnnul},  {12'd0, r.cannul});
`endif
    end
  end

  // Drive one cycle (called at posedge+1), record what the DUT must show, then advance the model.
  task automatic step(input logic rst, vld, fl, st, input logic [3:0] cd, alu,
                      input logic [FG-1:0] fw, input logic pcs_i, rw, mw);
    exp_t r;
    logic pass, lv, cex;
    reset = rst; ValidE = vld; FlushE = fl; StallE = st; Cond = cd;
    ALUFlags = alu; FlagW = fw; PCS = pcs_i; RegW = rw; MemW = mw;
    pass = model_pass(cd, mflags);
    lv   = vld && !fl;
    cex  = lv && pass;
    r.cex = cex; r.pcse = pcs_i && cex; r.flags = mflags;
    r.regm = mreg; r.memm = mmem; r.pcsm = mpcs; r.cexec = mexec; r.cannul = mannul;
    q.push_back(r);
    if (rst) begin
      mflags = 4'b0; mreg = 1'b0; mmem = 1'b0; mpcs = 1'b0; mexec = '0; mannul = '0;
    end else if (!st) begin
      if (cex)
        for (int b = 0; b < 4; b++)
          if (fw[(b * FG) / 4]) mflags[b] = alu[b];
      mreg = !fl && rw && cex;
      mmem = !fl && mw && cex;
      mpcs = !fl && pcs_i && cex;
      if (lv) begin
        if (pass) mexec++;
        else      mannul++;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; StallE = 1'b0; FlushE = 1'b0; ValidE = 1'b0; Cond = 4'hE;
    ALUFlags = 4'b0; FlagW = '0; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
    @(posedge clk); #1;
    mflags = 4'b0; mreg = 1'b0; mmem = 1'b0; mpcs = 1'b0; mexec = '0; mannul = '0;

    // Reset with an AL register writer pending, then first live AL writer
    step(1, 1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0);
    step(0, 1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0);
    step(0, 0, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0);
    // CMP -> BEQ back-to-back, Z set then Z clear
    step(0, 1, 0, 0, 4'hE, 4'b0100, 2'b11, 0, 0, 0);
    step(0, 1, 0, 0, 4'h0, 4'h0, 2'b00, 1, 0, 0);
    step(0, 1, 0, 0, 4'hE, 4'b0000, 2'b11, 0, 0, 0);
    step(0, 1, 0, 0, 4'h0, 4'h0, 2'b00, 1, 0, 0);
    // Partial write: low slice (C,V) only, then CS fails
    step(0, 1, 0, 0, 4'hE, 4'b1111, 2'b11, 0, 0, 0);
    step(0, 1, 0, 0, 4'hE, 4'b0000, 2'b01, 0, 0, 0);
    step(0, 1, 0, 0, 4'h2, 4'h0, 2'b00, 1, 1, 0);
    // Annulled writer leaves flags alone
    step(0, 1, 0, 0, 4'hE, 4'b0000, 2'b11, 0, 0, 0);
    step(0, 1, 0, 0, 4'h0, 4'b1111, 2'b11, 0, 1, 0);
    step(0, 1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0);
    // Stall holds, flush bubbles, both together holds
    step(0, 1, 0, 0, 4'hE, 4'h0, 2'b00, 1, 1, 1);
    step(0, 1, 0, 1, 4'hE, 4'b1010, 2'b11, 0, 1, 0);
    step(0, 1, 1, 0, 4'hE, 4'b1010, 2'b11, 1, 1, 1);
    step(0, 1, 0, 0, 4'hE, 4'h0, 2'b00, 1, 1, 1);
    step(0, 1, 1, 1, 4'hE, 4'b1111, 2'b11, 0, 0, 0);
    step(0, 1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0);
    // Reset mid-stall clears everything
    step(1, 1, 0, 1, 4'hE, 4'h0, 2'b00, 1, 1, 1);
    // Counter wrap: 17 AL, 3 NV, 2 stalled
    for (int i = 0; i < 17; i++) step(0, 1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0);
    for (int i = 0; i < 3; i++)  step(0, 1, 0, 0, 4'hF, 4'h0, 2'b00, 0, 1, 0);
    for (int i = 0; i < 2; i++)  step(0, 1, 0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0);
    step(0, 0, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
           4'($urandom), 4'($urandom), FG'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    step(0, 0, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
